// File: rtl/lab1_sys_ram_bist.sv
// Built-in self-test engine for the lab1 on-chip RAM: pattern fill, read-back compare, error report.
// Optional macro LAB1_RAM_BIST_INVERT_PASS_EN adds inverted-pattern write/read passes.
module lab1_sys_ram_bist #(
  parameter int DEPTH  = 10240,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       pattern_seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  output logic              ram_clken,
  input  logic [31:0]       ram_readdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
`ifdef LAB1_RAM_BIST_INVERT_PASS_EN
    S_INV_WRITE,
    S_INV_READ,
`endif
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_n;
  logic [31:0]       seed_q;
  logic              accept;
  logic [ADDR_W-1:0] addr_n;
  logic              cs_n, wr_n, inv_wr_n;
  logic [31:0]       base, pat_n, wdata_n;
  logic              rd_phase, inv_rd;
  logic              pipe_valid;
  logic [ADDR_W-1:0] pipe_addr;
  logic [31:0]       pipe_exp;
  logic [31:0]       rd_pat;

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    cs_n     = 1'b0;
    wr_n     = 1'b0;
    inv_wr_n = 1'b0;
    addr_n   = '0;
    unique case (state)
      S_IDLE, S_DONE: if (start) begin
        accept  = 1'b1;
        state_n = S_WRITE;
      end
      S_WRITE: if (ram_address == LAST_ADDR) state_n = S_READ;
`ifdef LAB1_RAM_BIST_INVERT_PASS_EN
      S_READ:      if (ram_address == LAST_ADDR) state_n = S_INV_WRITE;
      S_INV_WRITE: if (ram_address == LAST_ADDR) state_n = S_INV_READ;
      S_INV_READ:  if (ram_address == LAST_ADDR) state_n = S_DRAIN;
`else
      S_READ:      if (ram_address == LAST_ADDR) state_n = S_DRAIN;
`endif
      S_DRAIN: state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase

    // RAM-facing signals are computed for the next state so they can be registered
    // and line up with that state's cycle; a phase change restarts the address at 0.
    unique case (state_n)
      S_WRITE: begin cs_n = 1'b1; wr_n = 1'b1; end
      S_READ:  cs_n = 1'b1;
`ifdef LAB1_RAM_BIST_INVERT_PASS_EN
      S_INV_WRITE: begin cs_n = 1'b1; wr_n = 1'b1; inv_wr_n = 1'b1; end
      S_INV_READ:  cs_n = 1'b1;
`endif
      default: cs_n = 1'b0;
    endcase
    if (cs_n && (state_n == state)) addr_n = ram_address + 1'b1;

    base    = accept ? pattern_seed : seed_q;
    pat_n   = base + 32'(addr_n);
    wdata_n = wr_n ? (inv_wr_n ? ~pat_n : pat_n) : '0;
  end

  always_comb begin
    rd_phase = (state == S_READ);
    inv_rd   = 1'b0;
`ifdef LAB1_RAM_BIST_INVERT_PASS_EN
    if (state == S_INV_READ) begin
      rd_phase = 1'b1;
      inv_rd   = 1'b1;
    end
`endif
    rd_pat = seed_q + 32'(ram_address);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      seed_q         <= '0;
      ram_address    <= '0;
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;
      ram_writedata  <= '0;
      pipe_valid     <= 1'b0;
      pipe_addr      <= '0;
      pipe_exp       <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state          <= state_n;
      ram_address    <= addr_n;
      ram_chipselect <= cs_n;
      ram_write      <= wr_n;
      ram_writedata  <= wdata_n;
      if (accept) seed_q <= pattern_seed;

      // Read data arrives one cycle after the address, so address/expected are delayed to match.
      pipe_valid <= rd_phase;
      pipe_addr  <= ram_address;
      pipe_exp   <= inv_rd ? ~rd_pat : rd_pat;

      if (accept) begin
        err_count      <= '0;
        first_err_addr <= '0;
      end else if (pipe_valid && (ram_readdata != pipe_exp)) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (err_count == '0) first_err_addr <= pipe_addr;
      end
    end
  end

  assign busy           = (state != S_IDLE) && (state != S_DONE);
  assign done           = (state == S_DONE);
  assign pass           = done && (err_count == '0);
  assign ram_byteenable = 4'hF;
  assign ram_clken      = 1'b1;

endmodule
